// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT widths, complex field positions, unloader state codes
// and the bit-reversal helper used by every FFT address path.
package fft_pkg;

    localparam int FFT_ADDR_W = 5;
    localparam int FFT_DATA_W = 64;

    localparam int RE_MSB = 63;
    localparam int RE_LSB = 32;
    localparam int IM_MSB = 31;
    localparam int IM_LSB = 0;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Reverses the low w bits of v; bits at and above w come back zero.
    function automatic logic [15:0] bit_rev(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (i < w) r[i] = v[w-1-i];
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; a push into a full FIFO
// is taken only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             full, do_push, do_pop;

    always_comb begin
        empty   = count == '0;
        full    = count == CW'(DEPTH);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head    = mem[rp];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
            if (do_pop) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= push_data;
    end

endmodule

// File: rtl/fft_result_unloader.sv
// fft_result_unloader: streams the FFT result memory out as a valid/ready bin
// stream, issuing reads only against buffer credit so no read data is ever lost.
module fft_result_unloader
    import fft_pkg::*;
#(
    parameter int ADDR_W     = FFT_ADDR_W,
    parameter int DATA_W     = FFT_DATA_W,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter bit BIT_REV    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fft_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              overrun
);
    localparam int MW = ADDR_W + 1;
    localparam int PW = RD_LAT * MW;
    localparam int FW = DATA_W + MW;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t            state, state_nx;
    logic              done_q, rd_last, trig, start, pop, issue, is_last, empty;
    logic [ADDR_W-1:0] cnt, cur, addr;
    logic [RD_LAT-1:0] pipe_v;
    logic [PW-1:0]     pipe_m;
    logic [FW-1:0]     head;
    logic [CW-1:0]     count;
    int                occ;

    // occ is what the buffer will hold after this edge if every in-flight read lands
    always_comb begin
        trig     = fft_done & ~done_q;
        start    = trig & (state == ST_IDLE);
        pop      = out_valid & out_ready;
        occ      = int'(count) - int'(pop) + int'(rd_en) + $countones(pipe_v);
        issue    = (start | (state == ST_READ)) & (occ < FIFO_DEPTH);
        cur      = start ? '0 : cnt;
        is_last  = &cur;
        addr     = BIT_REV ? ADDR_W'(bit_rev(16'(cur), ADDR_W)) : cur;
        state_nx = start ? ST_READ
                 : (state == ST_READ && issue && is_last) ? ST_DRAIN
                 : (state == ST_DRAIN && pop && out_last) ? ST_IDLE
                 : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            done_q  <= 1'b1;
            cnt     <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            rd_last <= 1'b0;
            pipe_v  <= '0;
            pipe_m  <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            done_q  <= fft_done;
            overrun <= overrun | (trig & (state != ST_IDLE));
            rd_en   <= issue;
            pipe_v  <= RD_LAT'({pipe_v, rd_en});
            pipe_m  <= PW'({pipe_m, rd_last, rd_addr});
            if (issue) begin
                rd_addr <= addr;
                rd_last <= is_last;
                cnt     <= cur + ADDR_W'(1);
            end else if (start) begin
                cnt <= '0;
            end
        end
    end

    sync_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (pipe_v[RD_LAT-1]),
        .push_data({pipe_m[PW-1 -: MW], rd_data}),
        .pop      (pop),
        .head     (head),
        .empty    (empty),
        .count    (count)
    );

    assign busy      = state != ST_IDLE;
    assign out_valid = ~empty;
    assign out_data  = head[DATA_W-1:0];
    assign out_index = head[DATA_W +: ADDR_W];
    assign out_last  = ~empty & head[FW-1];

endmodule

// File: doc/fft_result_unloader.md
FFT_RESULT_UNLOADER -- requirements
Module: fft_result_unloader

Interface
REQ-001 Parameter: ADDR_W, default 5, log2 of transform size; N = 2^ADDR_W points.
REQ-002 Parameter: DATA_W, default 64, one complex sample (real in [63:32], imag in [31:0]).
REQ-003 Parameter: RD_LAT, default 2, result-memory read latency in cycles (1..4).
REQ-004 Parameter: FIFO_DEPTH, default 4, output buffer entries; SHALL be >= RD_LAT+2.
REQ-005 Parameter: BIT_REV, default 0; 1 = emit bins in bit-reversed address order.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 fft_done  input  1  FFT-complete level from address generator; rising edge requests unload.
REQ-009 rd_en  output  1  result-memory read strobe.
REQ-010 rd_addr  output  ADDR_W  result-memory read address.
REQ-011 rd_data  input  DATA_W  result-memory data, valid RD_LAT cycles after rd_en.
REQ-012 out_valid  output  1  stream data valid.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_data  output  DATA_W  FFT bin value.
REQ-015 out_index  output  ADDR_W  bin number of out_data (natural index, 0..N-1).
REQ-016 out_last  output  1  high with the final bin of a frame.
REQ-017 busy  output  1  unload in progress; FFT controller SHALL NOT start while high.
REQ-018 overrun  output  1  sticky: fft_done edge arrived while busy.

Function
REQ-019 States: IDLE, READ, DRAIN; reset state IDLE.
REQ-020 IDLE -> READ on fft_done rising edge (edge detected against registered previous value); read counter cleared to 0.
REQ-021 READ: issue rd_en with rd_addr = counter (or bit-reversed counter if BIT_REV=1) only when FIFO occupancy + reads in flight < FIFO_DEPTH; counter increments per issued read.
REQ-022 READ -> DRAIN in the cycle the read with counter = N-1 is issued.
REQ-023 DRAIN -> IDLE when FIFO empty, no reads in flight, and the out_last beat is accepted; busy deasserts the following cycle.
REQ-024 busy SHALL be high in READ and DRAIN, low in IDLE.
REQ-025 rd_data SHALL be captured into the FIFO exactly RD_LAT cycles after its rd_en via a RD_LAT-deep valid/index shift pipeline; no read data ever dropped.
REQ-026 Stream handshake: transfer when out_valid & out_ready; out_data/out_index/out_last SHALL hold stable while out_valid & !out_ready.
REQ-027 out_valid SHALL depend only on FIFO non-empty (no combinational path out_ready -> out_valid).
REQ-028 out_index SHALL equal the memory address of the word (natural bin index in both BIT_REV settings).
REQ-029 out_last SHALL be high on exactly one beat per frame, the N-th emitted beat.
REQ-030 Simultaneous FIFO write and read when full SHALL be permitted only when the read is accepted; credit scheme guarantees no write into a full FIFO.
REQ-031 With out_ready held high, throughput SHALL be one bin per cycle; first out_valid RD_LAT+1 cycles after the fft_done edge.
REQ-032 fft_done rising edge while busy: ignored for unloading, overrun set to 1 and held until reset.
REQ-033 fft_done held high after unload SHALL NOT retrigger (edge-only).

Reset
REQ-034 rst_n low SHALL asynchronously force: state IDLE, counters 0, FIFO empty, pipeline valids 0, rd_en 0, rd_addr 0, out_valid 0, out_last 0, busy 0, overrun 0.
REQ-035 Reset mid-frame SHALL discard all in-flight and buffered data; no beat emitted after release until a new fft_done edge.
REQ-036 Edge-detect register SHALL reset to 1 so fft_done already high at reset release does not trigger.

Structure
REQ-037 Shared package fft_pkg SHALL hold default ADDR_W, DATA_W, complex field slice positions, and the state enumeration.
REQ-038 Output buffer SHALL be one sub-module, sync_fifo (parameterised width/depth, count output).
REQ-039 Bit-reversal SHALL be a package function reused by the FFT address path.

Verification
REQ-040 Defaults, memory preloaded word k = k, out_ready=1, fft_done pulse -> 32 beats, data 0..31, index 0..31, out_last on beat 31, first beat 3 cycles after edge.
REQ-041 BIT_REV=1, same memory -> beat sequence 0,16,8,24,4,...,31; out_index equals out_data; out_last on beat value 31.
REQ-042 out_ready random 30% duty -> all 32 words in order, no loss/duplication, outputs stable while stalled, rd_en never overruns FIFO.
REQ-043 Second fft_done edge at beat 10 -> overrun=1 sticky, current frame completes unchanged, no second frame.
REQ-044 rst_n low at beat 15 with reads in flight -> all outputs reset immediately; after release no out_valid until new fft_done edge, then full clean frame.
REQ-045 fft_done high through reset release -> no unload; busy stays 0.
